// File: rtl/led_shift_pkg.sv
// Shared mode encodings for the LED shift engine and its mode-step sequencing.
package led_shift_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    SHIFT_R = 3'd0,
    SHIFT_L = 3'd1,
    ROT_R   = 3'd2,
    ROT_L   = 3'd3,
    GRAY    = 3'd4
  } mode_e;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      SHIFT_R: return SHIFT_L;
      SHIFT_L: return ROT_R;
      ROT_R:   return ROT_L;
      ROT_L:   return GRAY;
      default: return SHIFT_R;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider; tick is high in every cycle where the counter reads zero.
module tick_gen #(
  parameter int DIV_W = 23
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [DIV_W-1:0] cnt_q;

  // NOTE: clocked state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/led_shift_engine.sv
// LED pattern engine: synchronised keys step a 5-mode FSM that shifts, rotates or
// Gray-counts an active-low LED display on each divider tick.
module led_shift_engine
  import led_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       key,
  output logic [WIDTH-1:0] led,
  output logic [2:0]       mode,
  output logic             vcc_for_keys
);

  logic             tick;
  logic [2:0]       key_s1_q, key_s2_q;
  logic             step_prev_q;
  logic             data_on, step_on, clear_on, step_p;
  mode_e            mode_q;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] b_q, b_d, b_inc;

  tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Synchronisers reset to "released" so no phantom press appears after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q    <= 3'b111;
      key_s2_q    <= 3'b111;
      step_prev_q <= 1'b0;
    end else begin
      key_s1_q    <= key;
      key_s2_q    <= key_s1_q;
      step_prev_q <= step_on;
    end
  end

  assign data_on  = ~key_s2_q[2];
  assign step_on  = ~key_s2_q[1];
  assign clear_on = ~key_s2_q[0];
  assign step_p   = step_on & ~step_prev_q;

  // Clear suppresses stepping; illegal codes fall back to SHIFT_R on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= SHIFT_R;
    end else begin
      case (mode_q)
        SHIFT_R, SHIFT_L, ROT_R, ROT_L, GRAY: begin
          if (step_p && !clear_on) begin
            mode_q <= next_mode(mode_q);
          end
        end
        default: mode_q <= SHIFT_R;
      endcase
    end
  end

  assign b_inc = b_q + 1'b1;

  // NOTE: defaults first so every path assigns d_d/b_d and no latch is inferred.
  always_comb begin
    d_d = d_q;
    b_d = b_q;
    if (clear_on || step_p) begin
      d_d = '0;
      b_d = '0;
    end else if (tick) begin
      case (mode_q)
        SHIFT_R: d_d = {data_on, d_q[WIDTH-1:1]};
        SHIFT_L: d_d = {d_q[WIDTH-2:0], data_on};
        ROT_R:   d_d = {d_q[0] | data_on, d_q[WIDTH-1:1]};
        ROT_L:   d_d = {d_q[WIDTH-2:0], d_q[WIDTH-1] | data_on};
        GRAY: begin
          b_d = b_inc;
          d_d = b_inc ^ (b_inc >> 1);
        end
        default: d_d = d_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= '0;
      b_q <= '0;
    end else begin
      d_q <= d_d;
      b_q <= b_d;
    end
  end

  assign led          = ~d_q;
  assign mode         = mode_q;
  assign vcc_for_keys = 1'b1;

endmodule

// File: tb/tb_led_shift_engine.sv
// Scoreboard bench for led_shift_engine with WIDTH=8, DIV_W=2 (tick every 4 cycles).
module tb_led_shift_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] key;
  logic [7:0] led;
  logic [2:0] mode;
  logic       vcc_for_keys;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] exp_q[$];
  logic [1:0] div_m;

  always #5 clk = ~clk;

  led_shift_engine #(.WIDTH(8), .DIV_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .led         (led),
    .mode        (mode),
    .vcc_for_keys(vcc_for_keys)
  );

  // Independent tick reference: the edge taken while div_m==0 is a tick edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_m <= 2'd0;
    else        div_m <= div_m + 2'd1;
  end

  // Advance to 1 ns after the next tick edge (bounded).
  task automatic tick_step();
    bit was_tick = 1'b0;
    for (int k = 0; k < 8 && !was_tick; k++) begin
      was_tick = (div_m == 2'd0);
      @(posedge clk);
      #1;
    end
    if (!was_tick) begin
      n_total++;
      $display("FAIL tick_step no tick edge within 8 cycles (div_m=%0d)", div_m);
    end
  endtask

  task automatic press_step(input int hold);
    key[1] = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    key[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    rst_n = 1'b0;
    key   = 3'b111;
    #2;
    n_total++;
    if (led !== 8'hFF) $display("FAIL reset_led led=%h expected ff", led); else n_pass++;
    n_total++;
    if (mode !== 3'd0) $display("FAIL reset_mode mode=%0d expected 0", mode); else n_pass++;
    n_total++;
    if (vcc_for_keys !== 1'b1) $display("FAIL vcc vcc_for_keys=%b expected 1", vcc_for_keys); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < 8; i++) begin
      tick_step();
      exp = exp_q.pop_front();
      n_total++;
      if (led !== ~exp) $display("FAIL idle_tick[%0d] led=%h expected %h", i, led, ~exp); else n_pass++;
    end
  endtask

  task automatic test_shift_r();
    logic [7:0] exp;
    tick_step();
    exp = 8'h80;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(exp);
      exp = exp >> 1;
    end
    key[2] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick_step();
      if (i == 0) key[2] = 1'b1;
      exp = exp_q.pop_front();
      n_total++;
      if (led !== ~exp) $display("FAIL shift_r[%0d] led=%h expected %h", i, led, ~exp); else n_pass++;
    end
    n_total++;
    if (mode !== 3'd0) $display("FAIL shift_r_mode mode=%0d expected 0", mode); else n_pass++;
  endtask

  task automatic test_rot_r();
    logic [7:0] exp;
    press_step(12);
    n_total++;
    if (mode !== 3'd1) $display("FAIL held_step mode=%0d expected 1", mode); else n_pass++;
    press_step(3);
    n_total++;
    if (mode !== 3'd2) $display("FAIL rot_r_mode mode=%0d expected 2", mode); else n_pass++;
    tick_step();
    exp = 8'h80;
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(exp);
      exp = {exp[0], exp[7:1]};
    end
    key[2] = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick_step();
      if (i == 0) key[2] = 1'b1;
      exp = exp_q.pop_front();
      n_total++;
      if (led !== ~exp) $display("FAIL rot_r[%0d] led=%h expected %h", i, led, ~exp); else n_pass++;
    end
  endtask

  task automatic test_rot_l_clear();
    logic [7:0] exp;
    bit         seen = 1'b0;
    press_step(3);
    n_total++;
    if (mode !== 3'd3) $display("FAIL rot_l_mode mode=%0d expected 3", mode); else n_pass++;
    tick_step();
    key[2] = 1'b0;
    tick_step();
    key[2] = 1'b1;
    n_total++;
    if (led !== 8'hFE) $display("FAIL rot_l_load led=%h expected fe", led); else n_pass++;
    key[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (led === 8'hFF) seen = 1'b1;
    end
    n_total++;
    if (!seen) $display("FAIL clear_latency led=%h expected ff within 3 cycles", led); else n_pass++;
    key[2] = 1'b0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    for (int i = 0; i < 2; i++) begin
      tick_step();
      exp = exp_q.pop_front();
      n_total++;
      if (led !== ~exp) $display("FAIL clear_hold[%0d] led=%h expected %h", i, led, ~exp); else n_pass++;
    end
    n_total++;
    if (mode !== 3'd3) $display("FAIL clear_mode mode=%0d expected 3", mode); else n_pass++;
    key[0] = 1'b1;
    key[2] = 1'b1;
  endtask

  task automatic test_step_on_tick();
    tick_step();
    @(posedge clk);
    #1;
    key[1] = 1'b0;
    key[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (mode !== 3'd4) $display("FAIL step_tick_mode mode=%0d expected 4", mode); else n_pass++;
    n_total++;
    if (led !== 8'hFF) $display("FAIL step_tick_clear led=%h expected ff", led); else n_pass++;
    key[1] = 1'b1;
    key[2] = 1'b1;
  endtask

  task automatic test_gray();
    logic [7:0] b, exp;
    b = 8'h00;
    for (int i = 0; i < 256; i++) begin
      b = b + 8'h01;
      exp_q.push_back(b ^ (b >> 1));
    end
    for (int i = 0; i < 256; i++) begin
      tick_step();
      exp = exp_q.pop_front();
      n_total++;
      if (led !== ~exp) $display("FAIL gray[%0d] led=%h expected %h", i, led, ~exp); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_gray();
    logic [7:0] exp;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h06);
    for (int i = 0; i < 4; i++) begin
      tick_step();
      exp = exp_q.pop_front();
      n_total++;
      if (led !== ~exp) $display("FAIL pre_reset[%0d] led=%h expected %h", i, led, ~exp); else n_pass++;
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (led !== 8'hFF) $display("FAIL async_reset_led led=%h expected ff", led); else n_pass++;
    n_total++;
    if (mode !== 3'd0) $display("FAIL async_reset_mode mode=%0d expected 0", mode); else n_pass++;
    key[2] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (led !== 8'hFF) $display("FAIL post_reset_edge3 led=%h expected ff", led); else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (led !== 8'h7F) $display("FAIL post_reset_tick led=%h expected 7f", led); else n_pass++;
    key[2] = 1'b1;
  endtask

  initial begin
    test_reset();
    test_shift_r();
    test_rot_r();
    test_rot_l_clear();
    test_step_on_tick();
    test_gray();
    test_reset_mid_gray();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded 200000 ns");
    $fatal(1, "watchdog");
  end

endmodule
